// File: rtl/ps2_key_ctrl.sv
// PS/2 FIFO drain sequencer and scan-code decoder (E0/F0 prefix folding, held-key tracking).
// Optional macro PS2_KEY_TYPEMATIC_FILTER_EN suppresses auto-repeat make events of the held key.
//
// state  | meaning
// IDLE   | wait for kbd_ready, latch FIFO head and request pop
// POP    | release pop request; keyboard advances its read pointer
// DECODE | fold prefixes or emit an event from the latched byte
module ps2_key_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_POP    = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    logic [1:0]       state_q, state_d;
    logic [7:0]       code_q, code_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             evt_ext_q, evt_ext_d;
    logic             evt_brk_q, evt_brk_d;
    logic             key_down_q, key_down_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             err_ovf_q, err_ovf_d;
    logic             held_match;

    assign held_match = ({ext_pend_q, code_q} == {held_ext_q, held_code_q});

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        nextdata_n_d = nextdata_n_q;
        evt_valid_d  = 1'b0;
        evt_code_d   = evt_code_q;
        evt_ext_d    = evt_ext_q;
        evt_brk_d    = evt_brk_q;
        key_down_d   = key_down_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        press_cnt_d  = press_cnt_q;
        err_ovf_d    = err_ovf_q | kbd_overflow;

        case (state_q)
            S_IDLE: begin
                if (kbd_ready) begin
                    code_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                nextdata_n_d = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (code_q == PFX_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (code_q == PFX_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = code_q;
                        evt_ext_d   = ext_pend_q;
                        evt_brk_d   = 1'b1;
                        if (held_match && key_down_q)
                            key_down_d = 1'b0;
                    end else begin
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
                        // a make of the key already held is an auto-repeat: drop it entirely
                        if (!(held_match && key_down_q)) begin
                            evt_valid_d = 1'b1;
                            evt_code_d  = code_q;
                            evt_ext_d   = ext_pend_q;
                            evt_brk_d   = 1'b0;
                            held_code_d = code_q;
                            held_ext_d  = ext_pend_q;
                            key_down_d  = 1'b1;
                            press_cnt_d = press_cnt_q + CNT_W'(1);
                        end
`else
                        evt_valid_d = 1'b1;
                        evt_code_d  = code_q;
                        evt_ext_d   = ext_pend_q;
                        evt_brk_d   = 1'b0;
                        held_code_d = code_q;
                        held_ext_d  = ext_pend_q;
                        key_down_d  = 1'b1;
                        press_cnt_d = press_cnt_q + CNT_W'(1);
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            code_q       <= 8'h00;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            nextdata_n_q <= 1'b1;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= 8'h00;
            evt_ext_q    <= 1'b0;
            evt_brk_q    <= 1'b0;
            key_down_q   <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            press_cnt_q  <= '0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            nextdata_n_q <= nextdata_n_d;
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            evt_ext_q    <= evt_ext_d;
            evt_brk_q    <= evt_brk_d;
            key_down_q   <= key_down_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            press_cnt_q  <= press_cnt_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign evt_valid      = evt_valid_q;
    assign evt_code       = evt_code_q;
    assign evt_ext        = evt_ext_q;
    assign evt_brk        = evt_brk_q;
    assign key_down       = key_down_q;
    assign held_code      = held_code_q;
    assign held_ext       = held_ext_q;
    assign press_cnt      = press_cnt_q;
    assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO model feeding byte vectors, event scoreboard, and corner sequences.
// Honours PS2_KEY_TYPEMATIC_FILTER_EN when choosing expected results.
module tb_ps2_key_ctrl;
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       key_down;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_cnt;
    logic       err_ovf;

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
        .key_down(key_down), .held_code(held_code), .held_ext(held_ext),
        .press_cnt(press_cnt), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    typedef struct {
        logic [7:0] b;
        bit         ev;
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic       kd;
        logic [7:0] cnt;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] fifo[$];
    evt_t sb[$];
    vec_t vecs[$];
    int   ndn_pulses = 0;
    int   cyc = 0;
    int   last_evt = -1;
    bit   chk_spacing = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void add(input logic [7:0] b, input bit ev, input logic ext, input logic brk,
                                input logic [7:0] code, input logic kd, input logic [7:0] cnt);
        vecs.push_back('{b, ev, ext, brk, code, kd, cnt});
    endfunction

    // Keyboard FIFO model: head byte shown on kbd_data, popped when a pop request is seen
    initial begin
        bit prev_low;
        prev_low  = 1'b0;
        kbd_ready = 1'b0;
        kbd_data  = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (clrn && !kbd_nextdata_n) begin
                ndn_pulses++;
                if (prev_low) chk("nextdata_n_width", 32'd2, 32'd1);
                if (fifo.size() > 0) void'(fifo.pop_front());
            end
            prev_low  = clrn && !kbd_nextdata_n;
            kbd_ready = (fifo.size() > 0);
            kbd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    // Event monitor / scoreboard
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            #1;
            if (evt_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_evt", {23'd0, evt_ext, evt_brk, evt_code}, 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("evt_code", evt_code, e.code);
                    chk("evt_ext", evt_ext, e.ext);
                    chk("evt_brk", evt_brk, e.brk);
                end
                if (chk_spacing && last_evt >= 0) chk("evt_spacing", cyc - last_evt, 3);
                last_evt = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        fifo.push_back(b);
        repeat (6) @(negedge clk);
        if (fifo.size() != 0) chk("fifo_drain_timeout", fifo.size(), 0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int p0;
        int guard;
        clrn         = 1'b0;
        kbd_overflow = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_nextdata_n", kbd_nextdata_n, 1);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_code", evt_code, 0);
        chk("rst_evt_ext", evt_ext, 0);
        chk("rst_evt_brk", evt_brk, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_held_code", held_code, 0);
        chk("rst_held_ext", held_ext, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_err_ovf", err_ovf, 0);
        clrn = 1'b1;
        @(negedge clk);

        c = FILT ? 3 : 5;
        add(8'h1C, 1, 0, 0, 8'h1C, 1, 1);
        add(8'hF0, 0, 0, 0, 8'h00, 1, 1);
        add(8'h1C, 1, 0, 1, 8'h1C, 0, 1);
        add(8'hE0, 0, 0, 0, 8'h00, 0, 1);
        add(8'h75, 1, 1, 0, 8'h75, 1, 2);
        add(8'hE0, 0, 0, 0, 8'h00, 1, 2);
        add(8'hF0, 0, 0, 0, 8'h00, 1, 2);
        add(8'h75, 1, 1, 1, 8'h75, 0, 2);
        add(8'h1C, 1, 0, 0, 8'h1C, 1, 3);
        add(8'h1C, !FILT, 0, 0, 8'h1C, 1, FILT ? 8'd3 : 8'd4);
        add(8'h1C, !FILT, 0, 0, 8'h1C, 1, 8'(c));
        add(8'hF0, 0, 0, 0, 8'h00, 1, 8'(c));
        add(8'h1C, 1, 0, 1, 8'h1C, 0, 8'(c));
        add(8'hF0, 0, 0, 0, 8'h00, 0, 8'(c));
        add(8'hE0, 0, 0, 0, 8'h00, 0, 8'(c));
        add(8'h5A, 1, 1, 1, 8'h5A, 0, 8'(c));
        add(8'h2B, 1, 0, 0, 8'h2B, 1, 8'(c + 1));
        add(8'hF0, 0, 0, 0, 8'h00, 1, 8'(c + 1));
        add(8'h1C, 1, 0, 1, 8'h1C, 1, 8'(c + 1));
        add(8'hF0, 0, 0, 0, 8'h00, 1, 8'(c + 1));
        add(8'h2B, 1, 0, 1, 8'h2B, 0, 8'(c + 1));
        add(8'hE0, 0, 0, 0, 8'h00, 0, 8'(c + 1));
        add(8'hE0, 0, 0, 0, 8'h00, 0, 8'(c + 1));
        add(8'h74, 1, 1, 0, 8'h74, 1, 8'(c + 2));
        add(8'hF0, 0, 0, 0, 8'h00, 1, 8'(c + 2));
        add(8'hE0, 0, 0, 0, 8'h00, 1, 8'(c + 2));
        add(8'h74, 1, 1, 1, 8'h74, 0, 8'(c + 2));

        p0 = ndn_pulses;
        foreach (vecs[i]) begin
            if (vecs[i].ev) sb.push_back('{vecs[i].code, vecs[i].ext, vecs[i].brk});
            send_byte(vecs[i].b);
            chk($sformatf("v%0d_key_down", i), key_down, vecs[i].kd);
            chk($sformatf("v%0d_press_cnt", i), press_cnt, vecs[i].cnt);
            if (i == 2) chk("pop_pulses_first3", ndn_pulses - p0, 3);
        end
        chk("held_code_after_break", held_code, 8'h74);
        chk("held_ext_after_break", held_ext, 1);
        chk("sb_empty_vectors", sb.size(), 0);

        // 256 back-to-back makes with ready held high
        do_reset();
        for (int i = 0; i < 256; i++) begin
            fifo.push_back(8'h1C);
            if (!FILT || i == 0) sb.push_back('{8'h1C, 1'b0, 1'b0});
        end
        last_evt    = -1;
        chk_spacing = 1'b1;
        guard       = 0;
        while (fifo.size() > 0 && guard < 1200) begin
            @(negedge clk);
            guard++;
        end
        if (fifo.size() > 0) chk("wrap_drain_timeout", fifo.size(), 0);
        repeat (6) @(negedge clk);
        chk_spacing = 1'b0;
        chk("wrap_press_cnt", press_cnt, FILT ? 1 : 0);
        chk("wrap_sb_empty", sb.size(), 0);

        // reset while in POP after an F0 byte
        do_reset();
        sb.push_back('{8'h2B, 1'b0, 1'b0});
        send_byte(8'h2B);
        chk("pre_rst_key_down", key_down, 1);
        fifo.push_back(8'hF0);
        guard = 0;
        while (kbd_nextdata_n !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("pop_seen_before_rst", kbd_nextdata_n, 0);
        #2 clrn = 1'b0;
        #1;
        chk("midrst_nextdata_n", kbd_nextdata_n, 1);
        chk("midrst_key_down", key_down, 0);
        chk("midrst_press_cnt", press_cnt, 0);
        chk("midrst_held_code", held_code, 0);
        chk("midrst_evt_code", evt_code, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        sb.push_back('{8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        chk("post_rst_key_down", key_down, 1);
        chk("post_rst_press_cnt", press_cnt, 1);
        chk("post_rst_sb_empty", sb.size(), 0);

        // sticky overflow
        chk("ovf_before", err_ovf, 0);
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        #1;
        chk("ovf_next_cycle", err_ovf, 1);
        repeat (10) @(negedge clk);
        chk("ovf_sticky", err_ovf, 1);
        clrn = 1'b0;
        #1;
        chk("ovf_cleared_by_rst", err_ovf, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencer and scan-code decoder that sits directly behind `ps2_keyboard`. It drains the keyboard FIFO through the `ready`/`nextdata_n` handshake, one byte at a time. It folds the `E0` (extended) and `F0` (break) prefixes into single key events and tracks the currently held key. Downstream logic (display, ASCII mapping, key counters) consumes one-cycle event pulses plus level-held key state.

## Interface
Parameters:
- `CNT_W`, 8, width of the make-event counter `press_cnt`.

Ports:
- `clk`  in  1  system clock; same clock as `ps2_keyboard`.
- `clrn`  in  1  asynchronous, active-low reset.
- `kbd_data`  in  8  FIFO head byte from `ps2_keyboard.data`.
- `kbd_ready`  in  1  FIFO non-empty, from `ps2_keyboard.ready`.
- `kbd_overflow`  in  1  FIFO overflow flag, from `ps2_keyboard.overflow`.
- `kbd_nextdata_n`  out  1  pop request to `ps2_keyboard.nextdata_n`; active low.
- `evt_valid`  out  1  one-cycle pulse: a key event is on `evt_*`.
- `evt_code`  out  8  final scan code of the event (prefixes stripped).
- `evt_ext`  out  1  event was `E0`-prefixed.
- `evt_brk`  out  1  event is a release (`F0`-prefixed).
- `key_down`  out  1  a key is currently held.
- `held_code`  out  8  code of the held key (last make).
- `held_ext`  out  1  extended flag of the held key.
- `press_cnt`  out  CNT_W  count of emitted make events.
- `err_ovf`  out  1  sticky: `kbd_overflow` was seen high since reset.

## Operation
- The FSM has three states: IDLE, POP and DECODE.
- IDLE: if `kbd_ready`=1, latch `kbd_data` into `code_r`, drive `kbd_nextdata_n`<=0 and go to POP. Otherwise stay.
- POP: `kbd_nextdata_n`<=1 and go to DECODE. The keyboard advances `r_ptr` and updates `ready` on this edge.
- DECODE: process `code_r` and return to IDLE. `kbd_ready` is never sampled in POP or DECODE, because it is stale there.
- Decode rules in DECODE:
  - `code_r`==E0: set `ext_pend`. No event.
  - `code_r`==F0: set `brk_pend`. No event.
  - Any other value (including E1, AA, FA): form an event {`ext_pend`, `brk_pend`, `code_r`}, then clear both pending flags.
  - Prefixes accumulate in any order. E0 F0 xx and F0 E0 xx both give ext=1, brk=1. A repeated prefix is idempotent.
- Make event (brk=0): `held_code`<=code, `held_ext`<=ext, `key_down`<=1, pulse `evt_valid`, `press_cnt`<=`press_cnt`+1.
- Break event (brk=1):
  - Always pulse `evt_valid` with `evt_brk`=1.
  - If {ext, code} matches {`held_ext`, `held_code`} and `key_down`=1, set `key_down`<=0. `held_*` retain their value.
  - A non-matching break leaves `key_down` unchanged.
- `press_cnt` wraps modulo 2^CNT_W (at the default, 255 -> 0). Break events never count.
- `err_ovf`<=`err_ovf` | `kbd_overflow` on every cycle. It clears only on reset.

## Timing
- Reset values (asynchronous, `clrn`=0): state=IDLE, `kbd_nextdata_n`=1, `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0, `key_down`=0, `held_code`=0, `held_ext`=0, `press_cnt`=0, `err_ovf`=0, `ext_pend`=0, `brk_pend`=0.
- All outputs are registered.
- `kbd_nextdata_n` is low for exactly one cycle per byte.
- Throughput: one FIFO byte per 3 cycles.
- Latency: `ready` seen high in cycle t -> `nextdata_n` low in t+1 -> `evt_valid` high in t+3 (registered in DECODE).
- `evt_code`, `evt_ext` and `evt_brk` hold their values until the next event. They are qualified only by `evt_valid`.
- Back-to-back FIFO bytes give events no closer than 3 cycles apart.
- Reset asserted mid-sequence (in POP or DECODE): all state clears immediately and `nextdata_n` returns high. The byte may already have been popped; it is lost, and so are pending prefixes.
- `kbd_ready` deasserting on the pop edge (last byte) needs no special handling: IDLE simply waits.

## Configuration
- `PS2_KEY_TYPEMATIC_FILTER_EN` defined: a make event whose {ext, code} equals {`held_ext`, `held_code`} while `key_down`=1 is an auto-repeat. It is suppressed: no `evt_valid`, no `press_cnt` increment, and held state is unchanged.
- Not defined: every make event pulses `evt_valid` and increments `press_cnt`, including typematic repeats.

## Test plan
- Reset, then FIFO bytes 1C, F0, 1C -> make evt {ext=0, brk=0, 1C}, `key_down`=1, `press_cnt`=1. Then break evt {0, 1, 1C} and `key_down`=0. Exactly 3 `nextdata_n` low pulses, each 1 cycle.
- Bytes E0, 75, E0, F0, 75 -> evt {1, 0, 75} then {1, 1, 75}. `held_ext`=1. No events for the prefix bytes.
- Bytes 1C, 1C, 1C, F0, 1C:
  - With the filter macro: 1 make evt, `press_cnt`=1.
  - Without it: 3 make evts, `press_cnt`=3.
  - In both cases the final break clears `key_down`.
- Hold `kbd_ready`=1 with 256 make bytes 1C, F0-free, macro off -> `press_cnt` wraps to 0. `evt_valid` pulses are spaced exactly 3 cycles apart.
- Assert `clrn`=0 during POP after byte F0 -> all outputs return to reset values at once. The next byte 1C after release gives a make event (`brk_pend` cleared).
- Pulse `kbd_overflow` for 1 cycle -> `err_ovf`=1 from the next cycle and stays set until `clrn`=0.
